// File: rtl/gol_loader_pkg.sv
// Shared types and constants for the SD-card Game-of-Life pattern loader.
package gol_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_UNPACK,
        ST_DONE
    } state_t;

    localparam int BLOCK_BYTES = 512;
    localparam int BLOCK_BITS  = 4096;

    localparam logic [1:0] RD_INIT   = 2'd0;
    localparam logic [1:0] RD_READ   = 2'd1;
    localparam logic [1:0] RD_FINISH = 2'd2;

endpackage

// File: rtl/sd_block_unpacker.sv
// Walks one 512-byte SD block MSB-first and exposes the current bit and its
// cell offset within the block.
module sd_block_unpacker
    import gol_loader_pkg::*;
(
    input  logic                  clk_spi,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  advance,
    input  logic [BLOCK_BITS-1:0] blk_data,
    output logic                  bit_val,
    output logic                  last,
    output logic [11:0]           offset
);

    logic [8:0] byte_idx;
    logic [2:0] bit_idx;
    logic [7:0] cur_byte;

    // NOTE: sequential state is only ever assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_spi or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            bit_idx  <= '0;
        end else if (start) begin
            byte_idx <= '0;
            bit_idx  <= 3'd7;
        end else if (advance) begin
            if (bit_idx == 3'd0) begin
                bit_idx  <= 3'd7;
                byte_idx <= byte_idx + 9'd1;
            end else begin
                bit_idx <= bit_idx - 3'd1;
            end
        end
    end

    assign cur_byte = blk_data[{byte_idx, 3'b000} +: 8];
    assign bit_val  = cur_byte[bit_idx];
    assign last     = (byte_idx == 9'(BLOCK_BYTES - 1)) && (bit_idx == 3'd0);
    // Bit 7 is the leftmost cell, so the in-byte offset is the inverted bit index.
    assign offset   = {byte_idx, ~bit_idx};

endmodule

// File: rtl/sd_pattern_loader.sv
// Sequences the SD block reader over consecutive blocks and streams the
// received bits into the board RAM one cell per accepted write.
module sd_pattern_loader
    import gol_loader_pkg::*;
#(
    parameter int          CELLS   = 65536,
    parameter int          ADDR_W  = 16,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                  clk_spi,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           base_block,
    output logic [31:0]           blk_id,
    output logic                  blk_execute,
    input  logic [1:0]            blk_state,
    input  logic [BLOCK_BITS-1:0] blk_data,
    output logic                  cell_we,
    output logic [ADDR_W-1:0]     cell_addr,
    output logic                  cell_data,
    input  logic                  cell_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int              NBLK       = (CELLS + BLOCK_BITS - 1) / BLOCK_BITS;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_STEP = ADDR_W'(BLOCK_BITS);

    state_t            state;
    logic [31:0]       blk_cnt;
    logic [ADDR_W-1:0] block_base;
    logic [23:0]       wd;
    logic              pres_last;

    logic              unpack_start;
    logic              unpack_advance;
    logic              unpack_bit;
    logic              unpack_last;
    logic [11:0]       unpack_offset;
    logic              timeout_hit;
    logic              accept;
    logic              stop;
    logic              final_blk;
    logic              finish_seen;
    logic [ADDR_W-1:0] next_addr;

    assign finish_seen = (state == ST_WAIT) && (blk_state == RD_FINISH);
    assign timeout_hit = (wd == TIMEOUT - 24'd1);
    assign accept      = (state == ST_UNPACK) && cell_ready;
    // A block ends either at its last bit or at the board's last cell.
    assign stop        = pres_last || (cell_addr == LAST_ADDR);
    assign final_blk   = (cell_addr == LAST_ADDR) || (blk_cnt == 32'(NBLK - 1));

    // The unpacker always points at the cell to be presented next.
    assign unpack_start   = (state == ST_ISSUE);
    assign unpack_advance = finish_seen || (accept && !stop);
    assign next_addr      = block_base + ADDR_W'(unpack_offset);

    sd_block_unpacker u_unpacker (
        .clk_spi  (clk_spi),
        .reset_n  (reset_n),
        .start    (unpack_start),
        .advance  (unpack_advance),
        .blk_data (blk_data),
        .bit_val  (unpack_bit),
        .last     (unpack_last),
        .offset   (unpack_offset)
    );

    always_ff @(posedge clk_spi or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            blk_id      <= '0;
            blk_execute <= 1'b0;
            cell_we     <= 1'b0;
            cell_addr   <= '0;
            cell_data   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            blk_cnt     <= '0;
            block_base  <= '0;
            wd          <= '0;
            pres_last   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        blk_id      <= base_block;
                        blk_cnt     <= '0;
                        block_base  <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        blk_execute <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    blk_execute <= 1'b0;
                    wd          <= '0;
                    state       <= ST_ARM;
                end

                // A FINISH still showing here belongs to the previous block.
                ST_ARM: begin
                    if (blk_state != RD_FINISH) begin
                        wd    <= wd + 24'd1;
                        state <= ST_WAIT;
                    end else if (timeout_hit) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wd <= wd + 24'd1;
                    end
                end

                ST_WAIT: begin
                    if (finish_seen) begin
                        cell_we   <= 1'b1;
                        cell_addr <= next_addr;
                        cell_data <= unpack_bit;
                        pres_last <= unpack_last;
                        state     <= ST_UNPACK;
                    end else if (timeout_hit) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wd <= wd + 24'd1;
                    end
                end

                ST_UNPACK: begin
                    if (accept) begin
                        if (!stop) begin
                            cell_addr <= next_addr;
                            cell_data <= unpack_bit;
                            pres_last <= unpack_last;
                        end else begin
                            cell_we <= 1'b0;
                            if (final_blk) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                blk_cnt     <= blk_cnt + 32'd1;
                                blk_id      <= blk_id + 32'd1;
                                block_base  <= block_base + BLOCK_STEP;
                                blk_execute <= 1'b1;
                                state       <= ST_ISSUE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_pattern_loader.sv
// Scoreboard bench: two loader instances (4096 and 5000 cells) share one
// reader model; expected writes and block ids are queued when a load starts.
module tb_sd_pattern_loader;
    import gol_loader_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic        data;
    } cell_t;

    logic          clk_spi = 1'b0;
    logic          reset_n;
    logic [4095:0] blk_data;
    logic [1:0]    blk_state;
    logic          cell_ready;

    logic          start_a, start_b;
    logic [31:0]   base_a, base_b;
    logic [31:0]   blk_id_a, blk_id_b;
    logic          blk_execute_a, blk_execute_b;
    logic          cell_we_a, cell_we_b;
    logic [11:0]   cell_addr_a;
    logic [12:0]   cell_addr_b;
    logic          cell_data_a, cell_data_b;
    logic          busy_a, busy_b, done_a, done_b, error_a, error_b;

    cell_t         exp_a[$], exp_b[$];
    logic [31:0]   id_q_a[$], id_q_b[$];
    int            checks = 0;
    int            fails = 0;
    int            done_cnt_a = 0, done_cnt_b = 0, we_cnt_a = 0;
    logic [15:0]   last_addr_b;
    bit            reader_auto = 1'b1, use_pattern = 1'b0, bp_mode = 1'b0;
    logic [1:0]    man_state = RD_INIT;
    logic [4095:0] man_data = '0;
    logic [31:0]   rd_id;
    int            rd_cnt;
    int            a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    always #5 clk_spi = ~clk_spi;

    sd_pattern_loader #(.CELLS(4096), .ADDR_W(12), .TIMEOUT(24'd1000)) dut_a (
        .clk_spi(clk_spi), .reset_n(reset_n), .start(start_a), .base_block(base_a),
        .blk_id(blk_id_a), .blk_execute(blk_execute_a), .blk_state(blk_state),
        .blk_data(blk_data), .cell_we(cell_we_a), .cell_addr(cell_addr_a),
        .cell_data(cell_data_a), .cell_ready(cell_ready), .busy(busy_a),
        .done(done_a), .error(error_a)
    );

    sd_pattern_loader #(.CELLS(5000), .ADDR_W(13), .TIMEOUT(24'd100)) dut_b (
        .clk_spi(clk_spi), .reset_n(reset_n), .start(start_b), .base_block(base_b),
        .blk_id(blk_id_b), .blk_execute(blk_execute_b), .blk_state(blk_state),
        .blk_data(blk_data), .cell_we(cell_we_b), .cell_addr(cell_addr_b),
        .cell_data(cell_data_b), .cell_ready(cell_ready), .busy(busy_b),
        .done(done_b), .error(error_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string msg);
        checks++;
        fails++;
        $display("FAIL %s", msg);
    endtask

    function automatic logic [7:0] pat_byte(input logic [31:0] id, input int j);
        return 8'(j * 37) ^ id[7:0];
    endfunction

    function automatic logic [4095:0] make_block(input logic [31:0] id);
        logic [4095:0] b;
        for (int j = 0; j < 512; j++) b[j*8 +: 8] = pat_byte(id, j);
        return b;
    endfunction

    // Byte 0 = A5, everything else zero.
    task automatic push_a5_a(input logic [31:0] base);
        cell_t e;
        for (int a = 0; a < 4096; a++) begin
            e.addr = 16'(a);
            e.data = (a < 8) ? 1'(a5_bits[a]) : 1'b0;
            exp_a.push_back(e);
        end
        id_q_a.push_back(base);
    endtask

    task automatic push_pattern_b(input logic [31:0] base);
        cell_t       e;
        logic [31:0] id;
        logic [7:0]  bt;
        int          o;
        for (int a = 0; a < 5000; a++) begin
            id     = base + 32'(a / 4096);
            o      = a % 4096;
            bt     = pat_byte(id, o / 8);
            e.addr = 16'(a);
            e.data = bt[7 - (o % 8)];
            exp_b.push_back(e);
        end
        id_q_b.push_back(base);
        id_q_b.push_back(base + 32'd1);
    endtask

    task automatic pulse_start(input bit which);
        @(posedge clk_spi); #2;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk_spi); #2;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget, input string name);
        int n = 0;
        while (!(which ? done_b : done_a) && n < budget) begin
            @(negedge clk_spi);
            n++;
        end
        if (!(which ? done_b : done_a)) flag_fail({name, ": done never pulsed"});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_spi);
        #2;
    endtask

    // Reader model and ready generator: the only driver of the shared inputs.
    initial begin
        int ph = 0;
        blk_state  = RD_INIT;
        blk_data   = '0;
        cell_ready = 1'b1;
        rd_cnt     = 0;
        rd_id      = '0;
        forever begin
            @(posedge clk_spi); #1;
            cell_ready = bp_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ph++;
            if (!reader_auto) begin
                blk_state = man_state;
                blk_data  = man_data;
            end else if (blk_execute_a || blk_execute_b) begin
                blk_state = RD_READ;
                rd_cnt    = 3;
                rd_id     = blk_execute_b ? blk_id_b : blk_id_a;
            end else if (blk_state == RD_READ) begin
                if (rd_cnt == 0) begin
                    blk_data  = use_pattern ? make_block(rd_id) : man_data;
                    blk_state = RD_FINISH;
                end else begin
                    rd_cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and every block issue.
    initial begin
        cell_t       e;
        logic [31:0] id;
        bit          hold_a = 0, hold_b = 0;
        logic [12:0] pa_a = '0, pa_b = '0;
        logic        pd_a = 0, pd_b = 0;
        forever begin
            @(negedge clk_spi);
            if (cell_we_a) begin
                we_cnt_a++;
                if (hold_a) begin
                    check("hold_addr_a", 32'(cell_addr_a), 32'(pa_a));
                    check("hold_data_a", 32'(cell_data_a), 32'(pd_a));
                end
                if (cell_ready) begin
                    if (exp_a.size() == 0) flag_fail($sformatf("unexpected_write_a addr %0d", cell_addr_a));
                    else begin
                        e = exp_a.pop_front();
                        check("cell_addr_a", 32'(cell_addr_a), 32'(e.addr));
                        check("cell_data_a", 32'(cell_data_a), 32'(e.data));
                    end
                end
                hold_a = !cell_ready;
                pa_a   = 13'(cell_addr_a);
                pd_a   = cell_data_a;
            end else hold_a = 0;
            if (cell_we_b) begin
                if (hold_b) begin
                    check("hold_addr_b", 32'(cell_addr_b), 32'(pa_b));
                    check("hold_data_b", 32'(cell_data_b), 32'(pd_b));
                end
                if (cell_ready) begin
                    last_addr_b = 16'(cell_addr_b);
                    if (exp_b.size() == 0) flag_fail($sformatf("unexpected_write_b addr %0d", cell_addr_b));
                    else begin
                        e = exp_b.pop_front();
                        check("cell_addr_b", 32'(cell_addr_b), 32'(e.addr));
                        check("cell_data_b", 32'(cell_data_b), 32'(e.data));
                    end
                end
                hold_b = !cell_ready;
                pa_b   = cell_addr_b;
                pd_b   = cell_data_b;
            end else hold_b = 0;
            if (blk_execute_a) begin
                if (id_q_a.size() == 0) flag_fail("unexpected_execute_a");
                else begin id = id_q_a.pop_front(); check("blk_id_a", blk_id_a, id); end
            end
            if (blk_execute_b) begin
                if (id_q_b.size() == 0) flag_fail("unexpected_execute_b");
                else begin id = id_q_b.pop_front(); check("blk_id_b", blk_id_b, id); end
            end
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
        end
    end

    initial begin
        #700000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dcnt;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        base_a  = '0;
        base_b  = '0;
        cycles(3);
        check("rst_blk_id_a", blk_id_a, 32'd0);
        check("rst_execute_a", 32'(blk_execute_a), 32'd0);
        check("rst_we_a", 32'(cell_we_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_error_b", 32'(error_b), 32'd0);
        check("rst_addr_b", 32'(cell_addr_b), 32'd0);
        reset_n = 1'b1;
        cycles(2);

        // Single 4096-cell block, byte 0 = A5.
        man_data        = '0;
        man_data[7:0]   = 8'hA5;
        use_pattern     = 1'b0;
        base_a          = 32'd7;
        push_a5_a(32'd7);
        pulse_start(1'b0);
        check("busy_after_start_a", 32'(busy_a), 32'd1);
        wait_done(1'b0, 6000, "single_block");
        cycles(4);
        check("done_count_a", 32'(done_cnt_a), 32'd1);
        check("busy_fall_a", 32'(busy_a), 32'd0);
        check("queue_empty_a", 32'(exp_a.size()), 32'd0);

        // Two blocks (partial second), base 100.
        use_pattern = 1'b1;
        base_b      = 32'd100;
        push_pattern_b(32'd100);
        pulse_start(1'b1);
        wait_done(1'b1, 12000, "partial_block");
        cycles(4);
        check("done_count_b", 32'(done_cnt_b), 32'd1);
        check("last_addr_b", 32'(last_addr_b), 32'd4999);
        check("queue_empty_b", 32'(exp_b.size()), 32'd0);
        check("ids_used_b", 32'(id_q_b.size()), 32'd0);

        // Backpressure 1,0,0,1 with a block id that wraps.
        bp_mode = 1'b1;
        base_b  = 32'hFFFF_FFFF;
        push_pattern_b(32'hFFFF_FFFF);
        pulse_start(1'b1);
        wait_done(1'b1, 25000, "backpressure");
        bp_mode = 1'b0;
        cycles(4);
        check("bp_queue_empty_b", 32'(exp_b.size()), 32'd0);
        check("bp_last_addr_b", 32'(last_addr_b), 32'd4999);
        check("bp_done_count_b", 32'(done_cnt_b), 32'd2);

        // Stale FINISH must not start the unpack.
        reader_auto          = 1'b0;
        man_data             = '0;
        man_data[4095:4088]  = 8'h81;
        man_state            = RD_FINISH;
        cycles(3);
        we_cnt_a = 0;
        base_a   = 32'h20;
        id_q_a.push_back(32'h20);
        pulse_start(1'b0);
        n = 0;
        while (!blk_execute_a && n < 20) begin @(negedge clk_spi); n++; end
        if (!blk_execute_a) flag_fail("stale: blk_execute_a never seen");
        cycles(3);
        man_state = RD_INIT;
        cycles(4);
        check("stale_no_write", 32'(we_cnt_a), 32'd0);
        check("stale_busy", 32'(busy_a), 32'd1);
        for (int a = 0; a < 4096; a++) exp_a.push_back('{addr: 16'(a), data: (a == 4088 || a == 4095)});
        man_state = RD_FINISH;
        wait_done(1'b0, 6000, "stale_finish");
        cycles(3);
        check("stale_queue_empty", 32'(exp_a.size()), 32'd0);

        // Reader stuck in READ: watchdog fires after about TIMEOUT cycles.
        man_state = RD_READ;
        dcnt      = done_cnt_b;
        base_b    = 32'd5;
        id_q_b.push_back(32'd5);
        pulse_start(1'b1);
        n = 0;
        while (!error_b && n < 400) begin @(negedge clk_spi); n++; end
        check("timeout_window", 32'((n >= 100 && n <= 104) ? 1 : 0), 32'd1);
        check("timeout_error", 32'(error_b), 32'd1);
        check("timeout_busy", 32'(busy_b), 32'd0);
        cycles(5);
        check("timeout_no_done", 32'(done_cnt_b), 32'(dcnt));
        check("timeout_error_sticky", 32'(error_b), 32'd1);
        id_q_b.push_back(32'd5);
        pulse_start(1'b1);
        @(negedge clk_spi);
        check("restart_clears_error", 32'(error_b), 32'd0);
        check("restart_busy", 32'(busy_b), 32'd1);
        n = 0;
        while (!error_b && n < 400) begin @(negedge clk_spi); n++; end
        check("timeout_again", 32'(error_b), 32'd1);

        // Reset in the middle of an unpack.
        man_data      = '0;
        man_data[7:0] = 8'hA5;
        use_pattern   = 1'b0;
        reader_auto   = 1'b1;
        cycles(2);
        we_cnt_a = 0;
        base_a   = 32'd9;
        push_a5_a(32'd9);
        pulse_start(1'b0);
        n = 0;
        while (we_cnt_a < 50 && n < 200) begin @(negedge clk_spi); n++; end
        if (we_cnt_a < 50) flag_fail("reset_test: unpack never started");
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(cell_we_a), 32'd0);
        check("rst_mid_addr", 32'(cell_addr_a), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_blk_id", blk_id_a, 32'd0);
        exp_a.delete();
        id_q_a.delete();
        cycles(2);
        reset_n = 1'b1;
        cycles(20);
        check("post_reset_busy", 32'(busy_a), 32'd0);
        check("post_reset_we", 32'(cell_we_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
